cd7scan: RTL and testbench

CD7SCAN -- requirements
Module: cd7scan

---
 rtl/cd7scan.sv | 148 ++++++++++++++
 tb/tb_cd7scan.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cd7scan.sv
// Seven-segment display scanner: samples multiplexed segment/strobe lines,
// debounces each digit, decodes it to BCD and publishes complete 4-digit frames.
module cd7scan #(
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        err
);

  localparam logic [3:0] L_STABLE = 4'(STABLE);

  // Returns {bad, nibble}; unknown patterns decode to F and are flagged bad.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  // Stage p0: input sample registers
  logic [6:0]  r_seg_p0;
  logic [3:0]  r_dig_p0;
  logic        r_sv_p0;
  // Stage p1: previous sample, for the equality test
  logic [6:0]  r_seg_p1;
  logic [3:0]  r_dig_p1;
  logic        r_pv_p1;
  // Debounce and frame assembly state
  logic [3:0]  r_cnt;
  logic [15:0] r_shadow;
  logic [3:0]  r_cap;
  logic [3:0]  r_bad;
  logic [15:0] r_bcd;
  logic        r_valid;
  logic        r_err;

  logic        w_onehot;
  logic        w_same;
  logic [3:0]  w_cnt_nxt;
  logic        w_capture;
  logic        w_done;
  logic [4:0]  w_dec;
  logic [3:0]  w_cap_nxt;
  logic [3:0]  w_bad_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_p0 <= '0;
      r_dig_p0 <= '0;
      r_sv_p0  <= 1'b0;
    end else begin
      r_seg_p0 <= seg;
      r_dig_p0 <= dig;
      r_sv_p0  <= 1'b1;
    end
  end

  // The previous-sample flag forces the first post-reset sample to count as a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_p1 <= '0;
      r_dig_p1 <= '0;
      r_pv_p1  <= 1'b0;
    end else begin
      r_seg_p1 <= r_seg_p0;
      r_dig_p1 <= r_dig_p0;
      r_pv_p1  <= r_sv_p0;
    end
  end

  always_comb begin
    w_onehot  = (r_dig_p0 != 4'd0) && ((r_dig_p0 & (r_dig_p0 - 4'd1)) == 4'd0);
    w_same    = r_sv_p0 && r_pv_p1 &&
                ({r_dig_p0, r_seg_p0} == {r_dig_p1, r_seg_p1});
    w_cnt_nxt = 4'd0;
    if (w_onehot && w_same)
      w_cnt_nxt = (r_cnt == L_STABLE) ? r_cnt : r_cnt + 4'd1;
    else if (w_onehot)
      w_cnt_nxt = 4'd1;
    w_capture = (w_cnt_nxt == L_STABLE) && (r_cnt != L_STABLE);
    w_done    = (r_cap == 4'hF);
    w_dec     = seg_decode(r_seg_p0);
  end

  // A capture landing in the completion cycle is applied after the mask clear.
  always_comb begin
    w_cap_nxt = w_done ? 4'd0 : r_cap;
    w_bad_nxt = w_done ? 4'd0 : r_bad;
    if (w_capture) begin
      w_cap_nxt = w_cap_nxt | r_dig_p0;
      w_bad_nxt = (w_bad_nxt & ~r_dig_p0) | (w_dec[4] ? r_dig_p0 : 4'd0);
    end
  end

  // Stage p2: debounce counter, shadow slots and capture masks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_cap    <= '0;
      r_bad    <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_cap <= w_cap_nxt;
      r_bad <= w_bad_nxt;
      for (int i = 0; i < 4; i++) begin
        if (w_capture && r_dig_p0[i])
          r_shadow[i*4 +: 4] <= w_dec[3:0];
      end
    end
  end

  // Stage p3: frame publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_bcd <= r_shadow;
        r_err <= |r_bad;
      end
    end
  end

  assign bcd   = r_bcd;
  assign valid = r_valid;
  assign err   = r_err;

endmodule

// File: tb/tb_cd7scan.sv
// Directed bench for cd7scan: table of held {dig,seg} patterns with expected
// frame results, plus sequences for asynchronous reset and capture latency.
module tb_cd7scan;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic [15:0] bcd;
  logic        valid;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;

  cd7scan #(.STABLE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seg   (seg),
    .dig   (dig),
    .bcd   (bcd),
    .valid (valid),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic [6:0]  s;
    int          cyc;
    int          nv;
    logic [15:0] bcd;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] d, input logic [6:0] s, input int cyc,
                     input int nv, input logic [15:0] b, input logic e);
    vec_t v;
    v.d = d; v.s = s; v.cyc = cyc; v.nv = nv; v.bcd = b; v.err = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a pattern for n cycles, counting valid pulses seen 1ns after each edge.
  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    dig = d;
    seg = s;
    n_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) n_valid++;
    end
  endtask

  initial begin
    int k;
    bit got;

    // Frame 1234
    add(4'b0001, 7'h19, 6, 0, 16'h0000, 1'b0);
    add(4'b0010, 7'h30, 6, 0, 16'h0000, 1'b0);
    add(4'b0100, 7'h24, 6, 0, 16'h0000, 1'b0);
    add(4'b1000, 7'h79, 6, 1, 16'h1234, 1'b0);
    // Glitch on slot 0: a 3-cycle "0" must not capture
    add(4'b0001, 7'h40, 3, 0, 16'h1234, 1'b0);
    add(4'b0001, 7'h79, 6, 0, 16'h1234, 1'b0);
    add(4'b0010, 7'h02, 6, 0, 16'h1234, 1'b0);
    add(4'b0100, 7'h00, 6, 0, 16'h1234, 1'b0);
    add(4'b1000, 7'h10, 6, 1, 16'h9861, 1'b0);
    // Blank pattern in slot 2
    add(4'b0001, 7'h12, 6, 0, 16'h9861, 1'b0);
    add(4'b0010, 7'h30, 6, 0, 16'h9861, 1'b0);
    add(4'b0100, 7'h7F, 6, 0, 16'h9861, 1'b0);
    add(4'b1000, 7'h24, 6, 1, 16'h2F35, 1'b1);
    // Clean frame clears err; err holds until completion
    add(4'b0001, 7'h40, 6, 0, 16'h2F35, 1'b1);
    add(4'b0010, 7'h79, 6, 0, 16'h2F35, 1'b1);
    add(4'b0100, 7'h24, 6, 0, 16'h2F35, 1'b1);
    add(4'b1000, 7'h30, 6, 1, 16'h3210, 1'b0);
    // Overwrite slot 0 (5 then 9)
    add(4'b0001, 7'h12, 6, 0, 16'h3210, 1'b0);
    add(4'b0000, 7'h00, 2, 0, 16'h3210, 1'b0);
    add(4'b0001, 7'h10, 6, 0, 16'h3210, 1'b0);
    add(4'b0010, 7'h19, 6, 0, 16'h3210, 1'b0);
    add(4'b0100, 7'h02, 6, 0, 16'h3210, 1'b0);
    add(4'b1000, 7'h78, 6, 1, 16'h7649, 1'b0);
    // Non-one-hot and idle strobes never capture
    add(4'b0011, 7'h12, 20, 0, 16'h7649, 1'b0);
    add(4'b0000, 7'h00, 20, 0, 16'h7649, 1'b0);
    add(4'b1100, 7'h79, 20, 0, 16'h7649, 1'b0);
    // Long holds saturate: still one capture per slot, one valid
    add(4'b0001, 7'h79, 30, 0, 16'h7649, 1'b0);
    add(4'b0010, 7'h24, 30, 0, 16'h7649, 1'b0);
    add(4'b0100, 7'h30, 30, 0, 16'h7649, 1'b0);
    add(4'b1000, 7'h19, 30, 1, 16'h4321, 1'b0);

    dig   = 4'd0;
    seg   = 7'h7F;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bcd",   32'(bcd),   32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_err",   32'(err),   32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      hold(tbl[i].d, tbl[i].s, tbl[i].cyc);
      chk($sformatf("vec%0d_nvalid", i), 32'(n_valid),   32'(tbl[i].nv));
      chk($sformatf("vec%0d_bcd", i),    32'(bcd),       32'(tbl[i].bcd));
      chk($sformatf("vec%0d_err", i),    32'(err),       32'(tbl[i].err));
    end

    // Reset mid-frame: partial captures are lost, outputs clear asynchronously
    hold(4'b0001, 7'h12, 6);
    hold(4'b0010, 7'h12, 6);
    hold(4'b0100, 7'h12, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_bcd",   32'(bcd),   32'h0);
    chk("async_rst_valid", 32'(valid), 32'h0);
    chk("async_rst_err",   32'(err),   32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(4'b1000, 7'h78, 20);
    chk("post_rst_slot3_nvalid", 32'(n_valid), 32'h0);
    chk("post_rst_slot3_bcd",    32'(bcd),     32'h0);
    hold(4'b0001, 7'h40, 6);
    hold(4'b0010, 7'h40, 6);
    chk("post_rst_partial_nvalid", 32'(n_valid), 32'h0);

    // Completion latency: valid on the 6th edge after the last pattern appears
    dig = 4'b0100;
    seg = 7'h00;
    k   = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      @(posedge clk);
      #1;
      k++;
      if (valid === 1'b1) got = 1'b1;
    end
    chk("latency_seen",   32'(got), 32'h1);
    chk("latency_cycles", 32'(k),   32'd6);
    chk("latency_bcd",    32'(bcd), 32'h7800);
    chk("latency_err",    32'(err), 32'h0);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", 32'(valid), 32'h0);
    chk("bcd_holds",       32'(bcd),   32'h7800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
